// File: rtl/lm80c_pkg.sv
// Shared LM80C firmware memory map and the PRG uploader state encoding.
package lm80c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PTR_LO,
    PTR_HI,
    CHECK,
    ISSUE,
    FETCH,
    SEND,
    FINISH
  } state_t;

  // Firmware 3.13.3: start of BASIC program text and its end-of-program pointer.
  localparam logic [24:0] PRG_START_ADDR = 25'h8241;
  localparam logic [24:0] PTR_PROGND     = 25'h81BB;

endpackage

// File: rtl/prg_uploader.sv
// Reads the BASIC end-of-program pointer from work RAM, then streams the
// program bytes out of SDRAM over a valid/ready byte interface.
module prg_uploader #(
  parameter logic [24:0] PRG_START_ADDR = lm80c_pkg::PRG_START_ADDR,
  parameter logic [24:0] PTR_PROGND     = lm80c_pkg::PTR_PROGND,
  parameter int unsigned ADDR_W         = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              trigger,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_in,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       length,
  output logic              done,
  output logic              error
);
  import lm80c_pkg::*;

  localparam logic [15:0] START16 = PRG_START_ADDR[15:0];
  localparam logic [15:0] PTR16   = PTR_PROGND[15:0];

  state_t      state_q, state_d;
  logic        trig_q;
  logic        start_q, start_d;
  logic        rd_q, rd_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic [15:0] length_q, length_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] cur_q, cur_d;
  logic [15:0] rem_q, rem_d;
  logic        done_d, error_d;
  logic        done_q, error_q;
  logic [15:0] diff;

  assign diff = ptr_q - START16;

  always_ff @(posedge clk) begin
    trig_q <= trigger;
    if (reset) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      length_q    <= '0;
      ptr_q       <= '0;
      cur_q       <= '0;
      rem_q       <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      length_q    <= length_d;
      ptr_q       <= ptr_d;
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    length_d    = length_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    rem_d       = rem_q;
    done_d      = 1'b0;
    error_d     = 1'b0;

    // Only edges seen while idle arm a run; edges during a run are dropped.
    if (state_q == IDLE && trigger && !trig_q)
      start_d = 1'b1;

    unique case (state_q)
      IDLE: if (ena && start_q) begin
        start_d = 1'b0;
        busy_d  = 1'b1;
        addr_d  = PTR16;
        rd_d    = 1'b1;
        state_d = PTR_LO;
      end
      PTR_LO: if (ena) begin
        ptr_d[7:0] = data_in;
        addr_d     = PTR16 + 16'd1;
        state_d    = PTR_HI;
      end
      PTR_HI: if (ena) begin
        ptr_d[15:8] = data_in;
        rd_d        = 1'b0;
        state_d     = CHECK;
      end
      CHECK: if (ena) begin
        if (ptr_q <= START16) begin
          length_d = '0;
          error_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          length_d = diff;
          rem_d    = diff;
          cur_d    = START16;
          addr_d   = START16;
          rd_d     = 1'b1;
          state_d  = FETCH;
        end
      end
      ISSUE: if (ena) begin
        addr_d  = cur_q;
        rd_d    = 1'b1;
        state_d = FETCH;
      end
      FETCH: if (ena) begin
        out_data_d  = data_in;
        out_valid_d = 1'b1;
        rd_d        = 1'b0;
        state_d     = SEND;
      end
      // Handshake runs at full clk rate, independent of ena.
      SEND: if (out_ready) begin
        out_valid_d = 1'b0;
        rem_d       = rem_q - 16'd1;
        cur_d       = cur_q + 16'd1;
        state_d     = (rem_q == 16'd1) ? FINISH : ISSUE;
      end
      FINISH: if (ena) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd        = rd_q;
  assign addr      = {{(ADDR_W-16){1'b0}}, addr_q};
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign length    = length_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_prg_uploader.sv
// Directed bench for prg_uploader: SDRAM image model, byte sink and bus monitor.
module tb_prg_uploader;

  logic        clk = 1'b0;
  logic        reset, ena, trigger, rd, out_valid, out_ready, busy, done, error;
  logic [24:0] addr;
  logic [7:0]  data_in, out_data;
  logic [15:0] length;

  logic [7:0]  ram [0:65535];
  logic [7:0]  rx [$];
  int          tests = 0, fails = 0;
  int          done_cnt = 0, err_cnt = 0, valid_cnt = 0;

  always #5 clk = ~clk;

  assign data_in = ram[addr[15:0]];

  prg_uploader #(
    .PRG_START_ADDR(25'h8241),
    .PTR_PROGND    (25'h81BB),
    .ADDR_W        (25)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .trigger  (trigger),
    .rd       (rd),
    .addr     (addr),
    .data_in  (data_in),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .length   (length),
    .done     (done),
    .error    (error)
  );

  // ena strobes one clk in three
  initial begin
    int ecnt;
    ecnt = 0;
    ena  = 1'b0;
    forever begin
      @(negedge clk);
      ecnt = (ecnt + 1) % 3;
      ena  = (ecnt == 0);
    end
  end

  logic        ena_s = 1'b0, reset_s = 1'b1, prev_ok = 1'b0, prev_rd = 1'b0;
  logic [24:0] prev_addr = '0;

  always @(posedge clk) begin
    ena_s   <= ena;
    reset_s <= reset;
  end

  // Sink and bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) rx.push_back(out_data);
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (out_valid) valid_cnt++;
    if (done && error) begin
      tests++; fails++;
      $display("FAIL done_error_overlap: done=%b error=%b, required not both", done, error);
    end
    if (rd) begin
      tests++;
      if (addr[24:16] !== 9'd0) begin
        fails++;
        $display("FAIL addr_upper: addr=%h, required bits 24:16 zero", addr);
      end
    end
    if (prev_ok && !ena_s && !reset_s) begin
      tests++;
      if (rd !== prev_rd || addr !== prev_addr) begin
        fails++;
        $display("FAIL bus_stable: rd=%b addr=%h, required rd=%b addr=%h between enas",
                 rd, addr, prev_rd, prev_addr);
      end
    end
    prev_rd   = rd;
    prev_addr = addr;
    prev_ok   = 1'b1;
  end

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_obs;
    rx.delete();
    done_cnt  = 0;
    err_cnt   = 0;
    valid_cnt = 0;
  endtask

  task automatic pulse_trigger;
    @(negedge clk);
    trigger = 1'b1;
    tick(2);
    trigger = 1'b0;
  endtask

  task automatic load_ptr(input logic [15:0] p);
    ram[16'h81BB] = p[7:0];
    ram[16'h81BC] = p[15:8];
  endtask

  task automatic load_100;
    load_ptr(16'h8241 + 16'd100);
    for (int i = 0; i < 100; i++) ram[16'h8241 + i] = pat(i);
  endtask

  task automatic wait_run(input string name, input int limit);
    int n;
    n = 0;
    while (!busy && n < limit) begin @(negedge clk); n++; end
    while (busy && n < limit) begin @(negedge clk); n++; end
    tests++;
    if (n >= limit) begin
      fails++;
      $display("FAIL %s_timeout: busy=%b after %0d clks, required run to end", name, busy, n);
    end
    tick(4);
  endtask

  task automatic wait_rx(input string name, input int count);
    int n;
    n = 0;
    while (rx.size() < count && n < 2000) begin @(posedge clk); #1; n++; end
    tests++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL %s_timeout: got %0d bytes, required %0d", name, rx.size(), count);
    end
  endtask

  task automatic test_reset;
    trigger   = 1'b1;
    out_ready = 1'b1;
    reset     = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    tests++; if (rd !== 1'b0)        begin fails++; $display("FAIL reset_rd: got %b, required 0", rd); end
    tests++; if (addr !== 25'd0)     begin fails++; $display("FAIL reset_addr: got %h, required 0", addr); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    tests++; if (out_data !== 8'd0)  begin fails++; $display("FAIL reset_data: got %h, required 0", out_data); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests++; if (length !== 16'd0)   begin fails++; $display("FAIL reset_length: got %h, required 0", length); end
    tests++; if (done !== 1'b0 || error !== 1'b0)
      begin fails++; $display("FAIL reset_pulses: done=%b error=%b, required 0 0", done, error); end
    clear_obs();
    tick(30);
    tests++;
    if (busy !== 1'b0 || valid_cnt != 0 || done_cnt != 0 || err_cnt != 0) begin
      fails++;
      $display("FAIL held_trigger_norun: busy=%b done=%0d error=%0d, required no run",
               busy, done_cnt, err_cnt);
    end
    trigger = 1'b0;
    tick(2);
  endtask

  task automatic test_basic;
    logic [7:0] exp4 [4];
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_ptr(16'h8245);
    for (int i = 0; i < 4; i++) ram[16'h8241 + i] = exp4[i];
    clear_obs();
    out_ready = 1'b1;
    pulse_trigger();
    wait_run("basic", 2000);
    tests++; if (rx.size() != 4) begin fails++; $display("FAIL basic_count: got %0d, required 4", rx.size()); end
    for (int i = 0; i < 4 && i < rx.size(); i++) begin
      tests++;
      if (rx[i] !== exp4[i]) begin
        fails++; $display("FAIL basic_byte%0d: got %h, required %h", i, rx[i], exp4[i]);
      end
    end
    tests++; if (length !== 16'd4) begin fails++; $display("FAIL basic_length: got %0d, required 4", length); end
    tests++; if (done_cnt != 1 || err_cnt != 0)
      begin fails++; $display("FAIL basic_pulses: done=%0d error=%0d, required 1 0", done_cnt, err_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b, required 0", busy); end
  endtask

  task automatic test_stall;
    int held, n;
    clear_obs();
    out_ready = 1'b1;
    pulse_trigger();
    wait_rx("stall_first", 1);
    out_ready = 1'b0;
    held = 0;
    n    = 0;
    while (held < 10 && n < 2000) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        held++;
        tests++;
        if (out_data !== 8'h22 || rx.size() != 1) begin
          fails++;
          $display("FAIL stall_hold: data=%h bytes=%0d, required 22 with 1 byte", out_data, rx.size());
        end
      end
    end
    tests++;
    if (held < 10) begin fails++; $display("FAIL stall_timeout: held %0d clks, required 10", held); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_run("stall", 2000);
    tests++; if (rx.size() != 4) begin fails++; $display("FAIL stall_count: got %0d, required 4", rx.size()); end
    if (rx.size() == 4) begin
      tests++;
      if (rx[0] !== 8'h11 || rx[1] !== 8'h22 || rx[2] !== 8'h33 || rx[3] !== 8'h44) begin
        fails++;
        $display("FAIL stall_bytes: got %h %h %h %h, required 11 22 33 44", rx[0], rx[1], rx[2], rx[3]);
      end
    end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL stall_done: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_error;
    logic [15:0] ptrs [2];
    ptrs = '{16'h8241, 16'h8000};
    for (int k = 0; k < 2; k++) begin
      load_ptr(ptrs[k]);
      clear_obs();
      pulse_trigger();
      wait_run("error", 2000);
      tests++;
      if (err_cnt != 1 || done_cnt != 0 || valid_cnt != 0) begin
        fails++;
        $display("FAIL error_ptr_%h: error=%0d done=%0d valid=%0d, required 1 0 0",
                 ptrs[k], err_cnt, done_cnt, valid_cnt);
      end
      tests++;
      if (length !== 16'd0) begin
        fails++; $display("FAIL error_length_%h: got %0d, required 0", ptrs[k], length);
      end
    end
  endtask

  task automatic test_retrigger;
    int bad;
    load_100();
    clear_obs();
    out_ready = 1'b1;
    pulse_trigger();
    wait_rx("retrig_mid", 20);
    pulse_trigger();
    wait_run("retrig", 4000);
    tests++; if (rx.size() != 100) begin fails++; $display("FAIL retrig_count: got %0d, required 100", rx.size()); end
    bad = 0;
    for (int i = 0; i < rx.size() && i < 100; i++) if (rx[i] !== pat(i)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL retrig_bytes: %0d wrong, required 0", bad); end
    tests++; if (length !== 16'd100) begin fails++; $display("FAIL retrig_length: got %0d, required 100", length); end
    tick(40);
    tests++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      fails++; $display("FAIL retrig_norequeue: done=%0d busy=%b, required 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    load_100();
    clear_obs();
    out_ready = 1'b1;
    pulse_trigger();
    wait_rx("rmid_two", 2);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    tests++;
    if (!out_valid || out_data !== pat(2)) begin
      fails++; $display("FAIL rmid_byte3: valid=%b data=%h, required 1 %h", out_valid, out_data, pat(2));
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || rd !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rmid_abort: valid=%b rd=%b busy=%b, required 0 0 0", out_valid, rd, busy);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    tick(2);
    clear_obs();
    pulse_trigger();
    wait_run("rmid_restart", 4000);
    tests++; if (rx.size() != 100) begin fails++; $display("FAIL rmid_count: got %0d, required 100", rx.size()); end
    if (rx.size() > 0) begin
      tests++;
      if (rx[0] !== pat(0)) begin fails++; $display("FAIL rmid_first: got %h, required %h", rx[0], pat(0)); end
    end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL rmid_done: got %0d, required 1", done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    reset     = 1'b1;
    trigger   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_error();
    test_retrigger();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
